// File: rtl/flag_stack_reg.sv
// Condition-flag register with per-bit masked updates and a LIFO save/restore stack.
// Successor of the fixed N/V/Z register; for WIDTH=3 the bit order is {N, V, Z}.
module flag_stack_reg #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_en,
    input  logic [WIDTH-1:0] flag_mask,
    input  logic [WIDTH-1:0] in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] flag_out,
    output logic [CW-1:0]    stk_cnt,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic             full, empty;
    logic [CW-1:0]    top_idx;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] upd_val;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign top_idx = cnt_q - ONE_C;

    // CW always leaves headroom above DEPTH, so the wrapped index seen while
    // empty never matches a real entry and top_val reads as zero then.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == top_idx) begin
                top_val = stack_q[i];
            end
        end
    end

    always_comb begin
        upd_val = flags_q;
        if (flag_en) begin
            upd_val = (flags_q & ~flag_mask) | (in & flag_mask);
        end
    end

    always_comb begin
        flags_d = flags_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stack_d = stack_q;

        if (pop && !empty && push) begin
            // swap: current word goes to the top slot, old top comes back
            flags_d = top_val;
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == top_idx) begin
                    stack_d[i] = flags_q;
                end
            end
        end else if (pop && !empty) begin
            flags_d = top_val;
            cnt_d   = cnt_q - ONE_C;
        end else begin
            flags_d = upd_val;
            if (push) begin
                if (!full) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (CW'(i) == cnt_q) begin
                            stack_d[i] = flags_q;
                        end
                    end
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    err_d = 1'b1;
                end
            end else if (pop) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign flag_out  = flags_q;
    assign stk_cnt   = cnt_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_flag_stack_reg.sv
// Directed bench for flag_stack_reg: default 3x4 instance plus a 4-bit, 2-deep instance.
module tb_flag_stack_reg;

    logic       clk;
    logic       rst;

    logic       a_en, a_push, a_pop;
    logic [2:0] a_mask, a_in, a_out;
    logic [2:0] a_cnt;
    logic       a_full, a_empty, a_err;

    logic       b_en, b_push, b_pop;
    logic [3:0] b_mask, b_in, b_out;
    logic [1:0] b_cnt;
    logic       b_full, b_empty, b_err;

    int checks   = 0;
    int failures = 0;

    flag_stack_reg u_dut_a (
        .clk(clk), .rst(rst), .flag_en(a_en), .flag_mask(a_mask), .in(a_in),
        .push(a_push), .pop(a_pop), .flag_out(a_out), .stk_cnt(a_cnt),
        .stk_full(a_full), .stk_empty(a_empty), .stk_err(a_err)
    );

    flag_stack_reg #(.WIDTH(4), .DEPTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .flag_en(b_en), .flag_mask(b_mask), .in(b_in),
        .push(b_push), .pop(b_pop), .flag_out(b_out), .stk_cnt(b_cnt),
        .stk_full(b_full), .stk_empty(b_empty), .stk_err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inputs applied on a falling edge, one rising edge, outputs read on the next falling edge
    task automatic step_a(input logic en, input logic [2:0] m, input logic [2:0] d,
                          input logic ps, input logic pp);
        a_en = en; a_mask = m; a_in = d; a_push = ps; a_pop = pp;
        @(negedge clk);
        a_en = 1'b0; a_mask = '0; a_in = '0; a_push = 1'b0; a_pop = 1'b0;
    endtask

    task automatic step_b(input logic en, input logic [3:0] m, input logic [3:0] d,
                          input logic ps, input logic pp);
        b_en = en; b_mask = m; b_in = d; b_push = ps; b_pop = pp;
        @(negedge clk);
        b_en = 1'b0; b_mask = '0; b_in = '0; b_push = 1'b0; b_pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        a_en = 0; a_mask = 0; a_in = 0; a_push = 0; a_pop = 0;
        b_en = 0; b_mask = 0; b_in = 0; b_push = 0; b_pop = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_flags", 8'(a_out), 8'h0);
        chk("rst_cnt", 8'(a_cnt), 8'h0);
        chk("rst_empty", 8'(a_empty), 8'h1);
        chk("rst_full", 8'(a_full), 8'h0);
        chk("rst_err", 8'(a_err), 8'h0);
        rst = 1'b1;

        // masked update
        step_a(1, 3'b001, 3'b111, 0, 0);
        chk("mask_z", 8'(a_out), 8'h1);
        step_a(1, 3'b100, 3'b000, 0, 0);
        chk("mask_n_hold", 8'(a_out), 8'h1);
        step_a(0, 3'b111, 3'b110, 0, 0);
        chk("en_off_hold", 8'(a_out), 8'h1);

        // asynchronous reset between edges
        step_a(0, 0, 0, 1, 0);
        chk("pre_rst_cnt", 8'(a_cnt), 8'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_flags", 8'(a_out), 8'h0);
        chk("async_rst_cnt", 8'(a_cnt), 8'h0);
        @(negedge clk);
        rst = 1'b1;

        // push/pop ordering, pop overrides flag_en
        step_a(1, 3'b111, 3'b101, 0, 0);
        step_a(0, 0, 0, 1, 0);
        chk("order_cnt1", 8'(a_cnt), 8'h1);
        step_a(1, 3'b111, 3'b010, 0, 0);
        step_a(0, 0, 0, 1, 0);
        chk("order_cnt2", 8'(a_cnt), 8'h2);
        step_a(1, 3'b111, 3'b111, 0, 0);
        step_a(1, 3'b111, 3'b000, 0, 1);
        chk("order_pop1", 8'(a_out), 8'h2);
        chk("order_cnt3", 8'(a_cnt), 8'h1);
        step_a(0, 0, 0, 0, 1);
        chk("order_pop2", 8'(a_out), 8'h5);
        chk("order_cnt4", 8'(a_cnt), 8'h0);
        chk("order_empty", 8'(a_empty), 8'h1);
        chk("order_err", 8'(a_err), 8'h0);

        // overflow
        for (int i = 1; i <= 5; i++) begin
            step_a(1, 3'b111, (i == 5) ? 3'b110 : 3'(i), 0, 0);
            step_a(0, 0, 0, 1, 0);
            if (i == 4) begin
                chk("ovf_full4", 8'(a_full), 8'h1);
                chk("ovf_err4", 8'(a_err), 8'h0);
            end
        end
        chk("ovf_err5", 8'(a_err), 8'h1);
        chk("ovf_cnt5", 8'(a_cnt), 8'h4);
        for (int i = 4; i >= 1; i--) begin
            step_a(0, 0, 0, 0, 1);
            chk("ovf_pop", 8'(a_out), 8'(i));
        end
        chk("ovf_empty", 8'(a_empty), 8'h1);

        // underflow
        do_reset();
        step_a(1, 3'b111, 3'b110, 0, 1);
        chk("udf_flags", 8'(a_out), 8'h6);
        chk("udf_cnt", 8'(a_cnt), 8'h0);
        chk("udf_err", 8'(a_err), 8'h1);
        step_a(0, 0, 0, 1, 0);
        step_a(0, 0, 0, 0, 1);
        chk("udf_sticky", 8'(a_err), 8'h1);
        do_reset();
        chk("udf_cleared", 8'(a_err), 8'h0);

        // push+pop on empty stack acts as push with no error
        step_a(1, 3'b111, 3'b101, 0, 0);
        step_a(0, 0, 0, 1, 1);
        chk("pp_empty_cnt", 8'(a_cnt), 8'h1);
        chk("pp_empty_err", 8'(a_err), 8'h0);
        step_a(1, 3'b111, 3'b000, 0, 0);
        step_a(0, 0, 0, 0, 1);
        chk("pp_empty_pop", 8'(a_out), 8'h5);

        // simultaneous events
        do_reset();
        step_a(1, 3'b111, 3'b011, 0, 0);
        step_a(1, 3'b111, 3'b100, 1, 0);
        chk("sim_flags", 8'(a_out), 8'h4);
        chk("sim_cnt", 8'(a_cnt), 8'h1);
        step_a(1, 3'b111, 3'b111, 1, 1);
        chk("swap_flags", 8'(a_out), 8'h3);
        chk("swap_cnt", 8'(a_cnt), 8'h1);
        step_a(0, 0, 0, 0, 1);
        chk("swap_top", 8'(a_out), 8'h4);
        chk("swap_err", 8'(a_err), 8'h0);

        // WIDTH=4, DEPTH=2 instance
        do_reset();
        step_b(1, 4'b1000, 4'b1111, 0, 0);
        chk("b_bit3_set", 8'(b_out), 8'h8);
        step_b(0, 0, 0, 1, 0);
        step_b(1, 4'b1000, 4'b0111, 1, 0);
        chk("b_bit3_clr", 8'(b_out), 8'h0);
        chk("b_full", 8'(b_full), 8'h1);
        chk("b_cnt2", 8'(b_cnt), 8'h2);
        step_b(0, 0, 0, 1, 0);
        chk("b_ovf_err", 8'(b_err), 8'h1);
        chk("b_ovf_cnt", 8'(b_cnt), 8'h2);
        step_b(0, 0, 0, 0, 1);
        chk("b_pop1", 8'(b_out), 8'h8);
        step_b(0, 0, 0, 0, 1);
        chk("b_pop2", 8'(b_out), 8'h8);
        chk("b_empty", 8'(b_empty), 8'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_stack_reg.md
# flag_stack_reg

Parametrised condition-flag register with per-bit write masking and a hardware save/restore stack. It sits between the ALU flag outputs and the branch unit, as the drop-in successor of the fixed 3-bit N/V/Z flag register. It adds selective flag updates (for example, instructions that set only Z) and push/pop of the whole flag word for interrupt entry/exit and call nesting.

## Interface
- WIDTH, default 3: number of flag bits. Bit order for WIDTH=3 is {N, V, Z}, with N = bit 2.
- DEPTH, default 4: number of stack entries, minimum 2.
- CW, default $clog2(DEPTH+1): width of the occupancy count (derived parameter).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset. Clears all state immediately while low.
- flag_en, input, 1: flag update request.
- flag_mask, input, WIDTH: per-bit update enable. A bit updates only when flag_en=1 and its mask bit is 1.
- in, input, WIDTH: new flag values from the ALU.
- push, input, 1: save the current flag word onto the stack.
- pop, input, 1: restore the flag word from the top of the stack.
- flag_out, output, WIDTH: current flag word (registered).
- stk_cnt, output, CW: number of valid stack entries (registered).
- stk_full, output, 1: stk_cnt == DEPTH (combinational from the count).
- stk_empty, output, 1: stk_cnt == 0 (combinational from the count).
- stk_err, output, 1: sticky overflow/underflow error (registered).

## Operation
- Reset (rst=0): flag_out=0, stk_cnt=0, stk_err=0, all stack entries=0. Consequently stk_empty=1 and stk_full=0.
- Masked update (flag_en=1, no pop): flag_out[i] <= in[i] where flag_mask[i]=1; other bits hold. flag_en=0 means no update.
- Push only (not full): entry[stk_cnt] <= current flag_out (the pre-update value); stk_cnt+1. A masked update in the same cycle still applies to flag_out.
- Push when full: the stack is unchanged, stk_cnt is unchanged, stk_err <= 1. A same-cycle masked update still applies.
- Pop only (not empty): flag_out <= entry[stk_cnt-1]; stk_cnt-1. Pop overrides any same-cycle flag_en, so the restored value wins entirely.
- Pop when empty: flag_out follows the normal masked-update rule, stk_cnt stays 0, stk_err <= 1.
- Push and pop together, not empty: swap. entry[stk_cnt-1] <= current flag_out and flag_out <= old entry[stk_cnt-1]. stk_cnt is unchanged and flag_en is ignored.
- Push and pop together, empty: treated as push only, with no error.
- stk_err is sticky and is cleared only by reset.
- The stack is a LIFO addressed by stk_cnt with no wrap-around. The count never exceeds DEPTH and never drops below 0.
- Entries at or above stk_cnt are don't-care for output purposes but must never be observable on flag_out.

## Timing
- All registered outputs change one cycle after the sampling edge. There is no combinational path from in/flag_en/push/pop to flag_out.
- Latency:
  - update to visible flag: 1 cycle
  - push to stk_cnt increment: 1 cycle
  - pop to restored flags on flag_out: 1 cycle
- Back-to-back push then pop on consecutive cycles returns the flag_out value present at the push edge.
- Reset assertion mid-operation clears state asynchronously, without waiting for clk. Deassertion is expected to be synchronous to clk upstream. The first edge after deassertion behaves as a normal cycle.
- stk_full and stk_empty update in the same cycle as stk_cnt.

## Test plan
- Reset and masked update: release reset, apply in=3'b111, flag_mask=3'b001, flag_en=1 -> flag_out=3'b001 next cycle. Then apply in=3'b000, mask=3'b100 -> flag_out stays 3'b001. Assert rst=0 mid-cycle -> flag_out=0 and stk_cnt=0 before the next edge.
- Push/pop order: set flags to 3'b101, then push. Set to 3'b010, then push. Set to 3'b111. Pop -> 3'b010. Pop -> 3'b101. stk_cnt sequence is 1, 2, 1, 0, with stk_empty=1 at the end and stk_err=0.
- Overflow: push 5 times with DEPTH=4 -> stk_full=1 after the 4th push, stk_err=1 after the 5th, stk_cnt=4. Four pops then return the first four saved words in reverse order.
- Underflow: pop when empty with flag_en=1, mask=3'b111, in=3'b110 -> flag_out=3'b110, stk_cnt=0, stk_err=1. stk_err stays 1 until reset.
- Simultaneous events: with flags=3'b011, push and flag_en(in=3'b100, mask=3'b111) together -> the stack top holds 3'b011 and flag_out=3'b100. Then push+pop with flags=3'b100 -> flag_out=3'b011, top=3'b100, stk_cnt unchanged.
- Parametrisation: WIDTH=4, DEPTH=2 -> full at 2 entries, stk_cnt is 2 bits wide, and a 4-bit mask correctly isolates bit 3.
